// File: rtl/associate_multilane_if.sv
// Bundle of the three handshakes around the associative neuron: the argument
// stream in, the result stream out, and the error-return path (delta in,
// feedback out). The neuron itself uses the slave view; whatever feeds it
// arguments and deltas, and consumes results and feedback, uses the master view.
// Every stream transfers on a rising edge where valid and ready are both high;
// a raised valid holds with stable data until ready, and ready is ignored
// while its valid is low.
interface associate_multilane_if #(
    parameter int N  = 4,
    parameter int AW = 8,
    parameter int RW = 16
);
    logic                   train;
    logic                   arg_valid;
    logic [N-1:0][AW-1:0]   arg_data;
    logic                   arg_ready;
    logic                   res_valid;
    logic [RW-1:0]          res_data;
    logic                   res_ready;
    logic                   err_valid;
    logic [RW-1:0]          err_data;
    logic                   err_ready;
    logic                   fbk_valid;
    logic [N-1:0][RW-1:0]   fbk_data;
    logic                   fbk_ready;

    modport master (
        output train, arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
        input  arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
    );

    modport slave (
        input  train, arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
        output arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
    );
endinterface

// File: rtl/associate_multilane.sv
// Associative neuron with L parallel multiply lanes. Forward pass computes
// sat(bias + sum(w[n]*arg[n] >>> F)) over K = N/L cycles with running
// saturation; in training it returns sat(w[n]*delta >>> F) upstream and then
// applies saturating weight and bias updates, L weights per cycle.
module associate_multilane #(
    parameter int N    = 4,
    parameter int L    = 2,
    parameter int AW   = 8,
    parameter int RW   = 16,
    parameter int F    = 8,
    parameter int RATE = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    associate_multilane_if.slave  bus,
    output logic [2:0]            dbg_state
);
    localparam int K   = N / L;
    localparam int CW  = (K > 1) ? $clog2(K) : 1;
    localparam int NIW = (N > 1) ? $clog2(N) : 1;
    // Wide enough for w*delta plus headroom, so nothing wraps before saturation.
    localparam int XW  = 2 * RW + AW + 2;
    localparam logic signed [XW-1:0] SMAX = {{(XW-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {{(XW-RW+1){1'b1}}, {(RW-1){1'b0}}};

    if (N % L != 0) begin : g_bad_lanes
        $fatal(1, "associate_multilane: N must be a multiple of L");
    end

    typedef enum logic [2:0] {
        S_ARG, S_MAC, S_ACC, S_RES, S_DEL, S_ERR, S_FBK, S_UPD
    } state_t;

    function automatic logic signed [RW-1:0] sat_rw(input logic signed [XW-1:0] x);
        if (x > SMAX)      return SMAX[RW-1:0];
        else if (x < SMIN) return SMIN[RW-1:0];
        else               return x[RW-1:0];
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic                   cnt_last;
    logic [N-1:0][AW-1:0]   arg_q;
    logic signed [RW-1:0]   delta_q, bias_q, acc_q, res_q;
    logic signed [RW-1:0]   w_q [N];
    logic [N-1:0][RW-1:0]   fbk_q;
    logic signed [XW-1:0]   lane_sum_q, lane_sum_d;
    logic                   res_valid_q, fbk_valid_q;
    logic                   arg_ready, err_ready, arg_hs, res_hs, err_hs, fbk_hs;
    logic [NIW-1:0]         lane_idx [L];
    logic signed [RW-1:0]   fbk_lane [L];
    logic signed [RW-1:0]   w_new [L];

    assign cnt_last  = (cnt_q == CW'(K - 1));
    assign arg_ready = (state_q == S_ARG);
    assign err_ready = (state_q == S_DEL);
    assign arg_hs    = arg_ready && bus.arg_valid;
    assign err_hs    = err_ready && bus.err_valid;
    assign res_hs    = res_valid_q && bus.res_ready;
    assign fbk_hs    = fbk_valid_q && bus.fbk_ready;

    assign bus.arg_ready = arg_ready;
    assign bus.err_ready = err_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_q;
    assign bus.fbk_valid = fbk_valid_q;
    assign bus.fbk_data  = fbk_q;
    assign dbg_state     = state_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_ARG;
        else       state_q <= state_d;
    end

    // Next-state: pass sequencing and the training branch taken at the result handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARG: if (bus.arg_valid) state_d = S_MAC;
            S_MAC: if (cnt_last)      state_d = S_ACC;
            S_ACC:                    state_d = S_RES;
            S_RES: if (res_hs)        state_d = bus.train ? S_DEL : S_ARG;
            S_DEL: if (bus.err_valid) state_d = S_ERR;
            S_ERR: if (cnt_last)      state_d = S_FBK;
            S_FBK: if (fbk_hs)        state_d = S_UPD;
            S_UPD: if (cnt_last)      state_d = S_ARG;
            default: begin
                state_d = S_ARG;
`ifndef SYNTHESIS
                $error("associate_multilane: invalid state encoding, recovering to ARG");
`endif
            end
        endcase
    end

    // Lane arithmetic for the current lane group: forward products, feedback and new weights.
    always_comb begin
        logic signed [XW-1:0] prod;
        logic signed [RW-1:0] step;
        lane_sum_d = '0;
        prod       = '0;
        step       = '0;
        for (int l = 0; l < L; l++) begin
            lane_idx[l] = NIW'(cnt_q) * NIW'(L) + NIW'(l);
            prod        = (XW'(w_q[lane_idx[l]]) * $signed(XW'(arg_q[lane_idx[l]]))) >>> F;
            lane_sum_d  = lane_sum_d + prod;
            fbk_lane[l] = sat_rw((XW'(w_q[lane_idx[l]]) * XW'(delta_q)) >>> F);
            step        = sat_rw((XW'(delta_q) * $signed(XW'(arg_q[lane_idx[l]]))) >>> (F + RATE));
            w_new[l]    = sat_rw(XW'(w_q[lane_idx[l]]) + XW'(step));
        end
    end

    // Datapath registers: capture, accumulate, output holding, feedback and weight update.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            arg_q       <= '0;
            delta_q     <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            fbk_q       <= '0;
            lane_sum_q  <= '0;
            res_valid_q <= 1'b0;
            fbk_valid_q <= 1'b0;
            for (int n = 0; n < N; n++) w_q[n] <= '0;
        end else begin
            if (state_q == S_MAC || state_q == S_ERR || state_q == S_UPD)
                cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
            else
                cnt_q <= '0;

            if (arg_hs) begin
                arg_q <= bus.arg_data;
                acc_q <= bias_q;
            end
            if (err_hs) delta_q <= bus.err_data;

            // Lane sums are registered; the accumulator lags one cycle, drained in ACC.
            if (state_q == S_MAC) begin
                lane_sum_q <= lane_sum_d;
                if (cnt_q != '0) acc_q <= sat_rw(XW'(acc_q) + lane_sum_q);
            end
            if (state_q == S_ACC) acc_q <= sat_rw(XW'(acc_q) + lane_sum_q);

            if (state_q == S_RES) begin
                if (!res_valid_q) begin
                    res_valid_q <= 1'b1;
                    res_q       <= acc_q;
                end else if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                end
            end

            if (state_q == S_ERR)
                for (int l = 0; l < L; l++) fbk_q[lane_idx[l]] <= fbk_lane[l];

            if (state_q == S_FBK) begin
                if (!fbk_valid_q)        fbk_valid_q <= 1'b1;
                else if (bus.fbk_ready)  fbk_valid_q <= 1'b0;
            end

            if (state_q == S_UPD) begin
                for (int l = 0; l < L; l++) w_q[lane_idx[l]] <= w_new[l];
                if (cnt_q == '0) bias_q <= sat_rw(XW'(bias_q) + XW'(delta_q >>> RATE));
            end
        end
    end
endmodule

// File: tb/tb_associate_multilane.sv
// Bench for associate_multilane (N=4, L=2, AW=8, RW=16, F=8, RATE=2).
// Directed scenarios followed by randomized passes, all checked against an
// integer reference model of the neuron held in this file.
module tb_associate_multilane;
    localparam int N = 4;
    localparam int AW = 8;
    localparam int RW = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         failures = 0;

    logic [RW-1:0] exp_q[$];
    int            mw [N];
    int            mbias;

    associate_multilane_if #(.N(N), .AW(AW), .RW(RW)) bus ();

    associate_multilane #(.N(N), .L(2), .AW(AW), .RW(RW), .F(8), .RATE(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model.
    function automatic int sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic int model_fwd(input logic [N-1:0][AW-1:0] a);
        longint acc, s;
        acc = mbias;
        for (int c = 0; c < 2; c++) begin
            s = 0;
            for (int l = 0; l < 2; l++)
                s += (longint'(mw[c*2+l]) * longint'(a[c*2+l])) >>> 8;
            acc = sat16(acc + s);
        end
        return int'(acc);
    endfunction

    function automatic int model_fbk(input int n, input logic [RW-1:0] d);
        return sat16((longint'(mw[n]) * longint'($signed(d))) >>> 8);
    endfunction

    function automatic void model_update(input logic [N-1:0][AW-1:0] a, input logic [RW-1:0] d);
        int ds, u;
        ds = int'($signed(d));
        for (int n = 0; n < N; n++) begin
            u     = sat16((longint'(ds) * longint'(a[n])) >>> 10);
            mw[n] = sat16(longint'(mw[n]) + longint'(u));
        end
        mbias = sat16(longint'(mbias) + longint'(ds >>> 2));
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < N; n++) mw[n] = 0;
        mbias = 0;
        exp_q.delete();
    endfunction

    // Scoreboard comparison.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Driver tasks.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_arg(input logic [N-1:0][AW-1:0] a);
        int waitc = 0;
        bus.arg_valid = 1'b1;
        bus.arg_data  = a;
        while (!bus.arg_ready && waitc < 50) begin
            @(posedge clock); #1; waitc++;
        end
        check("arg_ready_wait", 16'(bus.arg_ready), 16'd1);
        @(posedge clock); #1;
        bus.arg_valid = 1'b0;
        bus.arg_data  = '0;
    endtask

    task automatic collect_res(input logic tr, input int stall, output logic [15:0] obs);
        int lat = 0;
        logic [15:0] e;
        e = pop_exp();
        while (!bus.res_valid && lat < 20) begin
            @(posedge clock); #1; lat++;
        end
        check("res_latency", 16'(lat), 16'd4);
        obs = bus.res_data;
        check("res_data", obs, e);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            check("res_hold_valid", 16'(bus.res_valid), 16'd1);
            check("res_hold_data", bus.res_data, e);
            check("res_hold_arg_ready", 16'(bus.arg_ready), 16'd0);
        end
        bus.train     = tr;
        bus.res_ready = 1'b1;
        @(posedge clock); #1;
        bus.res_ready = 1'b0;
        bus.train     = 1'b0;
        check("res_valid_drop", 16'(bus.res_valid), 16'd0);
        if (tr) check("err_ready_after_res", 16'(bus.err_ready), 16'd1);
        else    check("arg_ready_after_res", 16'(bus.arg_ready), 16'd1);
    endtask

    task automatic send_err(input logic [RW-1:0] d, input int stall,
                            output logic [N-1:0][RW-1:0] fobs);
        int waitc = 0;
        int lat = 0;
        logic [15:0] e [N];
        for (int n = 0; n < N; n++) e[n] = pop_exp();
        bus.err_valid = 1'b1;
        bus.err_data  = d;
        while (!bus.err_ready && waitc < 50) begin
            @(posedge clock); #1; waitc++;
        end
        check("err_ready_wait", 16'(bus.err_ready), 16'd1);
        @(posedge clock); #1;
        bus.err_valid = 1'b0;
        while (!bus.fbk_valid && lat < 20) begin
            @(posedge clock); #1; lat++;
        end
        check("fbk_latency", 16'(lat), 16'd3);
        fobs = bus.fbk_data;
        for (int n = 0; n < N; n++) check($sformatf("fbk[%0d]", n), fobs[n], e[n]);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            check("fbk_hold_valid", 16'(bus.fbk_valid), 16'd1);
            for (int n = 0; n < N; n++) check($sformatf("fbk_hold[%0d]", n), bus.fbk_data[n], e[n]);
            check("fbk_hold_arg_ready", 16'(bus.arg_ready), 16'd0);
        end
        bus.fbk_ready = 1'b1;
        @(posedge clock); #1;
        bus.fbk_ready = 1'b0;
        check("fbk_valid_drop", 16'(bus.fbk_valid), 16'd0);
    endtask

    task automatic infer_pass(input logic [N-1:0][AW-1:0] a, input int stall, output logic [15:0] obs);
        exp_q.push_back(16'(model_fwd(a)));
        send_arg(a);
        collect_res(1'b0, stall, obs);
    endtask

    task automatic train_pass(input logic [N-1:0][AW-1:0] a, input logic [RW-1:0] d,
                              input int rstall, input int fstall,
                              output logic [N-1:0][RW-1:0] fobs);
        logic [15:0] robs;
        exp_q.push_back(16'(model_fwd(a)));
        send_arg(a);
        collect_res(1'b1, rstall, robs);
        for (int n = 0; n < N; n++) exp_q.push_back(16'(model_fbk(n, d)));
        send_err(d, fstall, fobs);
        model_update(a, d);
    endtask

    // Directed then randomized stimulus.
    initial begin
        logic [N-1:0][AW-1:0] a_base, a_full, a_rnd;
        logic [N-1:0][RW-1:0] fobs;
        logic [15:0]          robs;
        logic [RW-1:0]        d_rnd;
        int                   neg_w [N];

        bus.train = 1'b0; bus.arg_valid = 1'b0; bus.arg_data = '0;
        bus.res_ready = 1'b0; bus.err_valid = 1'b0; bus.err_data = '0;
        bus.fbk_ready = 1'b0;
        a_base[0] = 8'd10; a_base[1] = 8'd20; a_base[2] = 8'd30; a_base[3] = 8'd40;
        for (int n = 0; n < N; n++) a_full[n] = 8'd255;
        neg_w[0] = -2; neg_w[1] = -5; neg_w[2] = -7; neg_w[3] = -10;

        // Reset values.
        do_reset();
        check("rst_res_valid", 16'(bus.res_valid), 16'd0);
        check("rst_fbk_valid", 16'(bus.fbk_valid), 16'd0);
        check("rst_arg_ready", 16'(bus.arg_ready), 16'd1);
        check("rst_err_ready", 16'(bus.err_ready), 16'd0);
        check("rst_res_data", bus.res_data, 16'd0);
        for (int n = 0; n < N; n++) check("rst_fbk_data", bus.fbk_data[n], 16'd0);

        // Zero weights give zero result.
        infer_pass(a_base, 0, robs);
        check("t1_res_zero", robs, 16'd0);

        // One training step with delta 1.0, then a re-run.
        train_pass(a_base, 16'h0100, 0, 0, fobs);
        infer_pass(a_base, 0, robs);
        check("t2_res65", robs, 16'd65);

        // Negative unit delta returns the negated weights.
        train_pass(a_base, 16'hFF00, 0, 0, fobs);
        for (int n = 0; n < N; n++) check($sformatf("t3_fbk_neg[%0d]", n), fobs[n], 16'(neg_w[n]));

        // Weight and bias saturation under repeated maximal deltas.
        do_reset();
        for (int i = 0; i < 5; i++) train_pass(a_full, 16'h7FFF, 0, 0, fobs);
        infer_pass(a_full, 0, robs);
        check("t4_res_sat", robs, 16'h7FFF);

        // Output holding under back-pressure on both result and feedback.
        train_pass(a_base, 16'h0100, 10, 10, fobs);

        // Reset in the middle of the feedback computation.
        exp_q.push_back(16'(model_fwd(a_base)));
        send_arg(a_base);
        collect_res(1'b1, 0, robs);
        bus.err_valid = 1'b1;
        bus.err_data  = 16'h0100;
        @(posedge clock); #1;
        bus.err_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        check("t6_res_valid", 16'(bus.res_valid), 16'd0);
        check("t6_fbk_valid", 16'(bus.fbk_valid), 16'd0);
        check("t6_arg_ready", 16'(bus.arg_ready), 16'd1);
        infer_pass(a_base, 0, robs);
        check("t6_res_zero", robs, 16'd0);

        // Randomized passes.
        for (int it = 0; it < 30; it++) begin
            for (int n = 0; n < N; n++) a_rnd[n] = 8'($urandom_range(0, 255));
            d_rnd = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1)
                train_pass(a_rnd, d_rnd, $urandom_range(0, 3), $urandom_range(0, 3), fobs);
            else
                infer_pass(a_rnd, $urandom_range(0, 3), robs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
